// File: rtl/addr_seq_gen.sv
// rtl/addr_seq_gen.sv - self-sequencing NTT/INTT/PWM butterfly address and twiddle generator
// Optional macro ADDR_SEQ_STAGE_GAP_EN inserts STAGE_GAP idle cycles between stages.
module addr_seq_gen #(
  parameter int LOG_N     = 8,
  parameter int LOG_BF    = 1,
  parameter int STAGE_GAP = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [1:0]                          opcode,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                out_valid,
  output logic [(2**LOG_BF)*LOG_N-1:0]        ie,
  output logic [(2**LOG_BF)*LOG_N-1:0]        io,
  output logic [(2**LOG_BF)*(LOG_N-1)-1:0]    tw_idx,
  output logic [$clog2(LOG_N)-1:0]            stage,
  output logic                                stage_last,
  output logic                                done
);
  localparam int BF  = 2**LOG_BF;
  localparam int AW  = LOG_N;
  localparam int TWW = LOG_N - 1;
  localparam int SW  = $clog2(LOG_N);
  localparam int CW  = LOG_N - 1 - LOG_BF;
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 2);

`ifdef ADDR_SEQ_STAGE_GAP_EN
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;
  logic [GW-1:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN} state_t;
`endif

  state_t              state_q, state_d;
  logic                pwm_q, pwm_d;
  logic                intt_q, intt_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic [BF*AW-1:0]    ie_q, ie_d;
  logic [BF*AW-1:0]    io_q, io_d;
  logic [BF*TWW-1:0]   tw_q, tw_d;

  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_q;
    intt_d  = intt_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef ADDR_SEQ_STAGE_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pwm_d   = opcode[1];
          intt_d  = (opcode == 2'b01);
          stage_d = (opcode == 2'b01) ? LAST_STAGE : '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (valid_q && out_ready) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else if (pwm_q || stage_q == (intt_q ? SW'(0) : LAST_STAGE)) begin
            state_d = ST_IDLE;
            stage_d = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d   = '0;
            stage_d = intt_q ? stage_q - 1'b1 : stage_q + 1'b1;
`ifdef ADDR_SEQ_STAGE_GAP_EN
            if (STAGE_GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = GW'(STAGE_GAP - 1);
            end
`endif
          end
        end
      end
`ifdef ADDR_SEQ_STAGE_GAP_EN
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_RUN;
        else             gap_d   = gap_q - 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next stage/beat so every output leaves a flop.
  int                sh;
  logic [AW-1:0]     t, e, o, mask;
  logic [TWW-1:0]    w;

  always_comb begin
    ie_d = '0;
    io_d = '0;
    tw_d = '0;
    t    = '0;
    e    = '0;
    o    = '0;
    w    = '0;
    sh   = LOG_N - 1 - int'(stage_d);
    mask = (AW'(1) << sh) - AW'(1);
    for (int l = 0; l < BF; l++) begin
      t = (AW'(cnt_d) << LOG_BF) | AW'(l);
      if (pwm_d) begin
        e = t << 1;
        o = e | AW'(1);
        w = (TWW'(1) << (LOG_N - 2)) + TWW'(t >> 1);
      end else begin
        e = ((t >> sh) << (sh + 1)) + (t & mask);
        o = e + (AW'(1) << sh);
        w = (TWW'(1) << stage_d) + TWW'(t >> sh);
      end
      if (state_d != ST_IDLE) begin
        ie_d[l*AW +: AW]   = e;
        io_d[l*AW +: AW]   = o;
        tw_d[l*TWW +: TWW] = w;
      end
    end
  end

  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_RUN);
    last_d  = (state_d == ST_RUN) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pwm_q   <= 1'b0;
      intt_q  <= 1'b0;
      stage_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ie_q    <= '0;
      io_q    <= '0;
      tw_q    <= '0;
`ifdef ADDR_SEQ_STAGE_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      intt_q  <= intt_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ie_q    <= ie_d;
      io_q    <= io_d;
      tw_q    <= tw_d;
`ifdef ADDR_SEQ_STAGE_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign ie         = ie_q;
  assign io         = io_q;
  assign tw_idx     = tw_q;
  assign stage      = stage_q;
  assign stage_last = last_q;
  assign done       = done_q;

endmodule
